// File: rtl/udp_rx_frame_parser.sv
// Receive-side Ethernet/IPv4/UDP parser: strips headers, filters on MAC/IP/port,
// packs UDP payload into WORD_BYTES-wide words with addresses and reports FCS status.
module udp_rx_frame_parser #(
  parameter logic [47:0] BOARD_MAC    = 48'h000a3501fec0,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [31:0] BOARD_IP     = 32'hc0a80002,
  parameter logic [15:0] UDP_PORT     = 16'd8080,
  parameter int          WORD_BYTES   = 4,
  parameter int          ADDR_W       = 9
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    e_rxdv,
  input  logic [7:0]              datain,
  output logic [8*WORD_BYTES-1:0] data_o,
  output logic                    data_o_valid,
  output logic [3:0]              data_o_bytes,
  output logic                    data_o_last,
  output logic [ADDR_W-1:0]       ram_wr_addr,
  output logic [47:0]             pc_mac,
  output logic [31:0]             pc_IP,
  output logic [15:0]             pc_port,
  output logic [15:0]             rx_data_length,
  output logic                    frame_done,
  output logic [2:0]              frame_err,
  output logic [3:0]              rx_state
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_PRE     = 4'd1;
  localparam logic [3:0] S_SFD     = 4'd2;
  localparam logic [3:0] S_MAC     = 4'd3;
  localparam logic [3:0] S_ETYPE   = 4'd4;
  localparam logic [3:0] S_IP      = 4'd5;
  localparam logic [3:0] S_UDP     = 4'd6;
  localparam logic [3:0] S_PAYLOAD = 4'd7;
  localparam logic [3:0] S_TAIL    = 4'd8;
  localparam logic [3:0] S_DROP    = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  localparam logic [2:0]  WB_LAST     = 3'(WORD_BYTES - 1);
  localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

  logic [3:0]              state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [2:0]              err_q, err_d;
  logic [39:0]             sh_q, sh_d;
  logic [31:0]             crc_q, crc_d;
  logic [47:0]             src_mac_q, src_mac_d;
  logic [31:0]             src_ip_q, src_ip_d;
  logic [15:0]             src_port_q, src_port_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             rem_q, rem_d;
  logic [2:0]              widx_q, widx_d;
  logic [8*WORD_BYTES-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0]       waddr_q, waddr_d;

  logic [8*WORD_BYTES-1:0] data_o_q, data_o_d;
  logic                    data_o_valid_q, data_o_valid_d;
  logic [3:0]              data_o_bytes_q, data_o_bytes_d;
  logic                    data_o_last_q, data_o_last_d;
  logic [ADDR_W-1:0]       ram_wr_addr_q, ram_wr_addr_d;
  logic [47:0]             pc_mac_q, pc_mac_d;
  logic [31:0]             pc_ip_q, pc_ip_d;
  logic [15:0]             pc_port_q, pc_port_d;
  logic [15:0]             rx_len_q, rx_len_d;
  logic                    frame_done_q, frame_done_d;
  logic [2:0]              frame_err_q, frame_err_d;

  // shv holds the most recent six bytes including the one being sampled now
  logic [47:0] shv;
  logic        mac_ok;
  logic        port_ok;
  assign shv     = {sh_q, datain};
  assign mac_ok  = (shv == BOARD_MAC) || (ACCEPT_BCAST && (shv == 48'hffff_ffff_ffff));
  assign port_ok = (UDP_PORT == 16'd0) || (shv[15:0] == UDP_PORT);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      err_q          <= '0;
      sh_q           <= '0;
      crc_q          <= '0;
      src_mac_q      <= '0;
      src_ip_q       <= '0;
      src_port_q     <= '0;
      len_q          <= '0;
      rem_q          <= '0;
      widx_q         <= '0;
      buf_q          <= '0;
      waddr_q        <= '0;
      data_o_q       <= '0;
      data_o_valid_q <= 1'b0;
      data_o_bytes_q <= '0;
      data_o_last_q  <= 1'b0;
      ram_wr_addr_q  <= '0;
      pc_mac_q       <= '0;
      pc_ip_q        <= '0;
      pc_port_q      <= '0;
      rx_len_q       <= '0;
      frame_done_q   <= 1'b0;
      frame_err_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      sh_q           <= sh_d;
      crc_q          <= crc_d;
      src_mac_q      <= src_mac_d;
      src_ip_q       <= src_ip_d;
      src_port_q     <= src_port_d;
      len_q          <= len_d;
      rem_q          <= rem_d;
      widx_q         <= widx_d;
      buf_q          <= buf_d;
      waddr_q        <= waddr_d;
      data_o_q       <= data_o_d;
      data_o_valid_q <= data_o_valid_d;
      data_o_bytes_q <= data_o_bytes_d;
      data_o_last_q  <= data_o_last_d;
      ram_wr_addr_q  <= ram_wr_addr_d;
      pc_mac_q       <= pc_mac_d;
      pc_ip_q        <= pc_ip_d;
      pc_port_q      <= pc_port_d;
      rx_len_q       <= rx_len_d;
      frame_done_q   <= frame_done_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Next state, per-state byte counter and latched frame status.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        err_d = '0;
        if (e_rxdv && datain == 8'h55) state_d = S_PRE;
      end
      S_PRE: begin
        if (e_rxdv && datain == 8'h55) begin
          if (cnt_q == 5'd5) begin
            state_d = S_SFD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SFD: state_d = (e_rxdv && datain == 8'hd5) ? S_MAC : S_IDLE;
      S_MAC: begin
        if (!e_rxdv) begin
          state_d = S_DONE;
          err_d   = 3'd5;
        end else if (cnt_q == 5'd5 && !mac_ok) begin
          state_d = S_DROP;
          err_d   = 3'd1;
        end else if (cnt_q == 5'd11) begin
          state_d = S_ETYPE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_ETYPE: begin
        if (!e_rxdv) begin
          state_d = S_DONE;
          err_d   = 3'd5;
        end else if (cnt_q == 5'd1) begin
          state_d = (shv[15:0] == 16'h0800) ? S_IP : S_DROP;
          err_d   = (shv[15:0] == 16'h0800) ? err_q : 3'd2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_IP: begin
        if (!e_rxdv) begin
          state_d = S_DONE;
          err_d   = 3'd5;
        end else if ((cnt_q == 5'd0 && datain != 8'h45) ||
                     (cnt_q == 5'd9 && datain != 8'd17)) begin
          state_d = S_DROP;
          err_d   = 3'd2;
        end else if (cnt_q == 5'd19) begin
          state_d = (shv[31:0] == BOARD_IP) ? S_UDP : S_DROP;
          err_d   = (shv[31:0] == BOARD_IP) ? err_q : 3'd3;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_UDP: begin
        if (!e_rxdv) begin
          state_d = S_DONE;
          err_d   = 3'd5;
        end else if (cnt_q == 5'd3 && !port_ok) begin
          state_d = S_DROP;
          err_d   = 3'd4;
        end else if (cnt_q == 5'd5 && shv[15:0] < 16'd8) begin
          state_d = S_DROP;
          err_d   = 3'd2;
        end else if (cnt_q == 5'd7) begin
          state_d = (len_q == 16'd8) ? S_TAIL : S_PAYLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_PAYLOAD: begin
        if (!e_rxdv) begin
          state_d = S_DONE;
          err_d   = 3'd5;
        end else if (rem_q == 16'd1) begin
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (!e_rxdv) begin
          state_d = S_DONE;
          err_d   = (crc_q == CRC_RESIDUE) ? 3'd0 : 3'd6;
        end
      end
      S_DROP:  if (!e_rxdv) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. data_o_valid is a one-cycle write strobe
  // with no backpressure: the consumer must take every word as it is issued.
  always_comb begin
    logic [8*WORD_BYTES-1:0] word_v;
    sh_d           = sh_q;
    crc_d          = crc_q;
    src_mac_d      = src_mac_q;
    src_ip_d       = src_ip_q;
    src_port_d     = src_port_q;
    len_d          = len_q;
    rem_d          = rem_q;
    widx_d         = widx_q;
    buf_d          = buf_q;
    waddr_d        = waddr_q;
    data_o_d       = data_o_q;
    data_o_valid_d = 1'b0;
    data_o_bytes_d = data_o_bytes_q;
    data_o_last_d  = data_o_last_q;
    ram_wr_addr_d  = ram_wr_addr_q;
    pc_mac_d       = pc_mac_q;
    pc_ip_d        = pc_ip_q;
    pc_port_d      = pc_port_q;
    rx_len_d       = rx_len_q;
    frame_done_d   = 1'b0;
    frame_err_d    = frame_err_q;
    word_v         = (widx_q == 3'd0) ? '0 : buf_q;

    if (e_rxdv) sh_d = shv[39:0];

    case (state_q)
      S_IDLE: begin
        widx_d        = '0;
        waddr_d       = '0;
        ram_wr_addr_d = '0;
      end
      S_SFD: crc_d = '1;
      S_DONE: begin
        frame_done_d = 1'b1;
        frame_err_d  = err_q;
      end
      default: ;
    endcase

    if (e_rxdv && state_q >= S_MAC && state_q <= S_TAIL) crc_d = crc_byte(crc_q, datain);

    if (e_rxdv && state_q == S_MAC && cnt_q == 5'd11) src_mac_d = shv;
    if (e_rxdv && state_q == S_IP && cnt_q == 5'd15) src_ip_d = shv[31:0];
    if (e_rxdv && state_q == S_UDP) begin
      if (cnt_q == 5'd1) src_port_d = shv[15:0];
      if (cnt_q == 5'd5) len_d = shv[15:0];
      if (cnt_q == 5'd7) begin
        pc_mac_d  = src_mac_q;
        pc_ip_d   = src_ip_q;
        pc_port_d = src_port_q;
        rx_len_d  = len_q - 16'd8;
        rem_d     = len_q - 16'd8;
      end
    end

    // First payload byte of a word lands in the MSBs; a fresh word starts zeroed.
    if (e_rxdv && state_q == S_PAYLOAD) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (widx_q == 3'(i)) word_v[8*(WORD_BYTES-1-i) +: 8] = datain;
      end
      rem_d = rem_q - 16'd1;
      if (widx_q == WB_LAST || rem_q == 16'd1) begin
        data_o_d       = word_v;
        data_o_valid_d = 1'b1;
        data_o_bytes_d = {1'b0, widx_q} + 4'd1;
        data_o_last_d  = (rem_q == 16'd1);
        ram_wr_addr_d  = waddr_q;
        waddr_d        = waddr_q + ADDR_W'(1);
        widx_d         = '0;
      end else begin
        buf_d  = word_v;
        widx_d = widx_q + 3'd1;
      end
    end
  end

  assign data_o         = data_o_q;
  assign data_o_valid   = data_o_valid_q;
  assign data_o_bytes   = data_o_bytes_q;
  assign data_o_last    = data_o_last_q;
  assign ram_wr_addr    = ram_wr_addr_q;
  assign pc_mac         = pc_mac_q;
  assign pc_IP          = pc_ip_q;
  assign pc_port        = pc_port_q;
  assign rx_data_length = rx_len_q;
  assign frame_done     = frame_done_q;
  assign frame_err      = frame_err_q;
  assign rx_state       = state_q;

endmodule

// File: tb/tb_udp_rx_frame_parser.sv
// Directed bench for udp_rx_frame_parser: three instances (default, no broadcast,
// any port) see the same byte stream; payload words of the default instance are scoreboarded.
module tb_udp_rx_frame_parser;

  localparam logic [47:0] BOARD_MAC = 48'h000a3501fec0;
  localparam logic [31:0] BOARD_IP  = 32'hc0a80002;
  localparam logic [47:0] SRC_MAC   = 48'h0123456789ab;
  localparam logic [31:0] SRC_IP    = 32'hc0a80001;
  localparam logic [15:0] SRC_PORT  = 16'd5000;
  localparam logic [31:0] EXP_W [5] = '{32'h01020304, 32'h05060708, 32'h090a0b0c,
                                        32'h0d0e0f10, 32'h11120000};

  logic       clk = 1'b0;
  logic       clr;
  logic       e_rxdv;
  logic [7:0] datain;

  logic [31:0] data_o_w       [3];
  logic        data_o_valid_w [3];
  logic [3:0]  data_o_bytes_w [3];
  logic        data_o_last_w  [3];
  logic [8:0]  ram_wr_addr_w  [3];
  logic [47:0] pc_mac_w       [3];
  logic [31:0] pc_ip_w        [3];
  logic [15:0] pc_port_w      [3];
  logic [15:0] rx_len_w       [3];
  logic        frame_done_w   [3];
  logic [2:0]  frame_err_w    [3];
  logic [3:0]  rx_state_w     [3];

  int checks = 0;
  int errors = 0;
  int done_cnt [3];
  logic [2:0] done_err [3];
  int sd [3];
  int sw;

  logic [7:0]  fb[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_bytes[$];
  logic        got_last[$];
  logic [8:0]  got_addr[$];

  // clock / reset block
  always #5 clk = ~clk;

  udp_rx_frame_parser dut (
    .clk(clk), .clr(clr), .e_rxdv(e_rxdv), .datain(datain),
    .data_o(data_o_w[0]), .data_o_valid(data_o_valid_w[0]), .data_o_bytes(data_o_bytes_w[0]),
    .data_o_last(data_o_last_w[0]), .ram_wr_addr(ram_wr_addr_w[0]), .pc_mac(pc_mac_w[0]),
    .pc_IP(pc_ip_w[0]), .pc_port(pc_port_w[0]), .rx_data_length(rx_len_w[0]),
    .frame_done(frame_done_w[0]), .frame_err(frame_err_w[0]), .rx_state(rx_state_w[0])
  );

  udp_rx_frame_parser #(.ACCEPT_BCAST(1'b0)) dut_nb (
    .clk(clk), .clr(clr), .e_rxdv(e_rxdv), .datain(datain),
    .data_o(data_o_w[1]), .data_o_valid(data_o_valid_w[1]), .data_o_bytes(data_o_bytes_w[1]),
    .data_o_last(data_o_last_w[1]), .ram_wr_addr(ram_wr_addr_w[1]), .pc_mac(pc_mac_w[1]),
    .pc_IP(pc_ip_w[1]), .pc_port(pc_port_w[1]), .rx_data_length(rx_len_w[1]),
    .frame_done(frame_done_w[1]), .frame_err(frame_err_w[1]), .rx_state(rx_state_w[1])
  );

  udp_rx_frame_parser #(.UDP_PORT(16'd0)) dut_p0 (
    .clk(clk), .clr(clr), .e_rxdv(e_rxdv), .datain(datain),
    .data_o(data_o_w[2]), .data_o_valid(data_o_valid_w[2]), .data_o_bytes(data_o_bytes_w[2]),
    .data_o_last(data_o_last_w[2]), .ram_wr_addr(ram_wr_addr_w[2]), .pc_mac(pc_mac_w[2]),
    .pc_IP(pc_ip_w[2]), .pc_port(pc_port_w[2]), .rx_data_length(rx_len_w[2]),
    .frame_done(frame_done_w[2]), .frame_err(frame_err_w[2]), .rx_state(rx_state_w[2])
  );

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (data_o_valid_w[0]) begin
      got_data.push_back(data_o_w[0]);
      got_bytes.push_back(data_o_bytes_w[0]);
      got_last.push_back(data_o_last_w[0]);
      got_addr.push_back(ram_wr_addr_w[0]);
    end
    for (int k = 0; k < 3; k++) begin
      if (frame_done_w[k]) begin
        done_cnt[k] <= done_cnt[k] + 1;
        done_err[k] <= frame_err_w[k];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fbk;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fbk = r[0] ^ b[i];
      r   = {1'b0, r[31:1]};
      if (fbk) r = r ^ 32'hedb88320;
    end
    return r;
  endfunction

  task automatic push_bytes(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
  endtask

  // 64-byte frame: 14 MAC + 20 IP + 8 UDP + 18 payload + 4 FCS, after 8 preamble/SFD bytes
  task automatic build(input logic [47:0] dmac, input logic [15:0] dport, input bit flip);
    logic [31:0] crc;
    fb.delete();
    for (int i = 0; i < 7; i++) fb.push_back(8'h55);
    fb.push_back(8'hd5);
    push_bytes(dmac, 6);
    push_bytes(SRC_MAC, 6);
    push_bytes(48'h0800, 2);
    push_bytes(48'h4500002e0000, 6);
    push_bytes(48'h000040110000, 6);
    push_bytes({16'h0, SRC_IP}, 4);
    push_bytes({16'h0, BOARD_IP}, 4);
    push_bytes({32'h0, SRC_PORT}, 2);
    push_bytes({32'h0, dport}, 2);
    push_bytes(48'd26, 2);
    push_bytes(48'h0, 2);
    for (int i = 1; i <= 18; i++) fb.push_back(8'(i));
    crc = 32'hffffffff;
    for (int i = 8; i < fb.size(); i++) crc = crc_step(crc, fb[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) fb.push_back(crc[8*i +: 8]);
    if (flip) fb[fb.size()-1] = fb[fb.size()-1] ^ 8'h01;
  endtask

  task automatic snap();
    for (int k = 0; k < 3; k++) sd[k] = done_cnt[k];
    sw = got_data.size();
  endtask

  // driver: cut > 0 sends only the first cut bytes
  task automatic send(input int cut);
    int n;
    n = (cut > 0) ? cut : fb.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e_rxdv = 1'b1;
      datain = fb[i];
    end
    @(negedge clk);
    e_rxdv = 1'b0;
    datain = 8'h00;
    repeat (16) @(negedge clk);
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(EXP_W[i]);
  endtask

  task automatic check_words(input string tag, input int n, input bit has_last);
    int          got;
    logic [31:0] e;
    got = got_data.size() - sw;
    chk({tag, "_nwords"}, 64'(got), 64'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (sw + i < got_data.size()) begin
        chk($sformatf("%s_data%0d", tag, i), 64'(got_data[sw+i]), 64'(e));
        chk($sformatf("%s_addr%0d", tag, i), 64'(got_addr[sw+i]), 64'(i));
        chk($sformatf("%s_bytes%0d", tag, i), 64'(got_bytes[sw+i]),
            (has_last && i == n - 1) ? 64'd2 : 64'd4);
        chk($sformatf("%s_last%0d", tag, i), 64'(got_last[sw+i]),
            64'(has_last && i == n - 1));
      end
    end
  endtask

  task automatic check_done(input string tag, input int k, input logic [2:0] e);
    chk($sformatf("%s_done%0d", tag, k), 64'(done_cnt[k] - sd[k]), 64'd1);
    chk($sformatf("%s_err%0d", tag, k), 64'(done_err[k]), 64'(e));
  endtask

  initial begin
    clr    = 1'b0;
    e_rxdv = 1'b0;
    datain = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_data", 64'(data_o_w[0]), 64'd0);
    chk("rst_valid", 64'(data_o_valid_w[0]), 64'd0);
    chk("rst_bytes", 64'(data_o_bytes_w[0]), 64'd0);
    chk("rst_last", 64'(data_o_last_w[0]), 64'd0);
    chk("rst_addr", 64'(ram_wr_addr_w[0]), 64'd0);
    chk("rst_pc_mac", 64'(pc_mac_w[0]), 64'd0);
    chk("rst_pc_ip", 64'(pc_ip_w[0]), 64'd0);
    chk("rst_pc_port", 64'(pc_port_w[0]), 64'd0);
    chk("rst_len", 64'(rx_len_w[0]), 64'd0);
    chk("rst_done", 64'(frame_done_w[0]), 64'd0);
    chk("rst_err", 64'(frame_err_w[0]), 64'd0);
    chk("rst_state", 64'(rx_state_w[0]), 64'd0);
    clr = 1'b1;
    repeat (4) @(negedge clk);

    // valid frame
    build(BOARD_MAC, 16'd8080, 1'b0);
    push_exp(5);
    snap();
    send(0);
    check_words("good", 5, 1'b1);
    for (int k = 0; k < 3; k++) check_done("good", k, 3'd0);
    chk("good_len", 64'(rx_len_w[0]), 64'd18);
    chk("good_pc_mac", 64'(pc_mac_w[0]), 64'(SRC_MAC));
    chk("good_pc_ip", 64'(pc_ip_w[0]), 64'(SRC_IP));
    chk("good_pc_port", 64'(pc_port_w[0]), 64'(SRC_PORT));

    // wrong destination MAC
    build(48'h000a3501fec1, 16'd8080, 1'b0);
    snap();
    send(0);
    check_words("badmac", 0, 1'b0);
    for (int k = 0; k < 3; k++) check_done("badmac", k, 3'd1);
    chk("badmac_hold", 64'(frame_err_w[0]), 64'd1);

    // broadcast destination
    build(48'hffffffffffff, 16'd8080, 1'b0);
    snap();
    send(0);
    check_done("bcast", 0, 3'd0);
    check_done("bcast", 1, 3'd1);
    check_done("bcast", 2, 3'd0);

    // wrong destination port
    build(BOARD_MAC, 16'd1234, 1'b0);
    snap();
    send(0);
    check_done("port", 0, 3'd4);
    check_done("port", 1, 3'd4);
    check_done("port", 2, 3'd0);

    // corrupted FCS: payload still delivered
    build(BOARD_MAC, 16'd8080, 1'b1);
    push_exp(5);
    snap();
    send(0);
    check_words("fcs", 5, 1'b1);
    check_done("fcs", 0, 3'd6);

    // e_rxdv drops after 8 payload bytes
    build(BOARD_MAC, 16'd8080, 1'b0);
    push_exp(2);
    snap();
    send(8 + 42 + 8);
    check_words("trunc", 2, 1'b0);
    check_done("trunc", 0, 3'd5);

    // reset asserted mid-payload
    build(BOARD_MAC, 16'd8080, 1'b0);
    snap();
    for (int i = 0; i < 8 + 42 + 6; i++) begin
      @(negedge clk);
      e_rxdv = 1'b1;
      datain = fb[i];
    end
    @(negedge clk);
    clr    = 1'b0;
    datain = fb[8 + 42 + 6];
    @(negedge clk);
    chk("clr_valid", 64'(data_o_valid_w[0]), 64'd0);
    chk("clr_data", 64'(data_o_w[0]), 64'd0);
    chk("clr_state", 64'(rx_state_w[0]), 64'd0);
    chk("clr_addr", 64'(ram_wr_addr_w[0]), 64'd0);
    chk("clr_pc_mac", 64'(pc_mac_w[0]), 64'd0);
    chk("clr_len", 64'(rx_len_w[0]), 64'd0);
    chk("clr_err", 64'(frame_err_w[0]), 64'd0);
    e_rxdv = 1'b0;
    datain = 8'h00;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (16) @(negedge clk);
    chk("clr_nodone", 64'(done_cnt[0] - sd[0]), 64'd0);

    // recovery with a clean frame
    build(BOARD_MAC, 16'd8080, 1'b0);
    push_exp(5);
    snap();
    send(0);
    check_words("again", 5, 1'b1);
    check_done("again", 0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
